// File: rtl/ysyx_22040210_instqueue_pkg.sv
// Instruction queue shared definitions: depth, entry field widths and offsets.
// Entry layout (MSB..LSB): {inst, pc, bhr, pht, taken, takenaddr}.
package ysyx_22040210_instqueue_pkg;

    localparam int IQ_DEPTH = 16;

    localparam int INST_W  = 32;
    localparam int PC_W    = 64;
    localparam int BHR_W   = 8;
    localparam int PHT_W   = 2;
    localparam int TAKEN_W = 1;
    localparam int TADDR_W = 64;

    localparam int IQ_ENT_W =
        INST_W + PC_W + BHR_W + PHT_W + TAKEN_W + TADDR_W;

    localparam int TADDR_LSB = 0;
    localparam int TAKEN_LSB = TADDR_LSB + TADDR_W;
    localparam int PHT_LSB   = TAKEN_LSB + TAKEN_W;
    localparam int BHR_LSB   = PHT_LSB + PHT_W;
    localparam int PC_LSB    = BHR_LSB + BHR_W;
    localparam int INST_LSB  = PC_LSB + PC_W;

    function automatic logic [1:0] min2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ysyx_22040210_iq_ram.sv
// Instruction queue storage: DEPTH x ENT_W, two write ports, two async reads.
// Ports: clk; we*/waddr*/wdata* write ports; raddr*/rdata* read ports.
module ysyx_22040210_iq_ram #(
    parameter int DEPTH = 16,
    parameter int ENT_W = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we1_i,
    input  logic [AW-1:0]    waddr1_i,
    input  logic [ENT_W-1:0] wdata1_i,
    input  logic             we2_i,
    input  logic [AW-1:0]    waddr2_i,
    input  logic [ENT_W-1:0] wdata2_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [ENT_W-1:0] rdata1_o,
    input  logic [AW-1:0]    raddr2_i,
    output logic [ENT_W-1:0] rdata2_o
);

    logic [ENT_W-1:0] mem_q [DEPTH];

    // The two write addresses are always tail and tail+1, so never collide.
    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/ysyx_22040210_instqueue.sv
// Dual-push / dual-pop instruction queue between fetch and issue.
// Ports: clk, rst, flush; push1/push2 in; push_ready_o; pop_num_i; out1/out2; count_o.
module ysyx_22040210_instqueue
    import ysyx_22040210_instqueue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int ENT_W = IQ_ENT_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push1_valid_i,
    input  logic [ENT_W-1:0] push1_data_i,
    input  logic             push2_valid_i,
    input  logic [ENT_W-1:0] push2_data_i,
    output logic             push_ready_o,
    input  logic [1:0]       pop_num_i,
    output logic             out1_valid_o,
    output logic [ENT_W-1:0] out1_data_o,
    output logic             out2_valid_o,
    output logic [ENT_W-1:0] out2_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       p1, p2;
    logic [1:0] n_push;
    logic [1:0] pop_req;
    logic [1:0] cnt_lo;
    logic [1:0] n_pop;

    assign push_ready_o = (count_q <= CNT_W'(DEPTH - 2));

    // A lone push2 is ignored; pushes are dropped while not ready.
    assign p1 = push_ready_o & push1_valid_i;
    assign p2 = push_ready_o & push1_valid_i & push2_valid_i;
    assign n_push = {1'b0, p1} + {1'b0, p2};

    // pop_num_i=3 is a no-op; otherwise clip to the current occupancy.
    assign pop_req = (pop_num_i == 2'd3) ? 2'd0 : pop_num_i;
    assign cnt_lo  = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    assign n_pop   = min2(pop_req, cnt_lo);

    always_comb begin
        head_d  = head_q + PTR_W'(n_pop);
        tail_d  = tail_q + PTR_W'(n_push);
        count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    ysyx_22040210_iq_ram #(
        .DEPTH (DEPTH),
        .ENT_W (ENT_W)
    ) u_ram (
        .clk      (clk),
        .we1_i    (p1 & ~flush & ~rst),
        .waddr1_i (tail_q),
        .wdata1_i (push1_data_i),
        .we2_i    (p2 & ~flush & ~rst),
        .waddr2_i (tail_q + PTR_W'(1)),
        .wdata2_i (push2_data_i),
        .raddr1_i (head_q),
        .rdata1_o (out1_data_o),
        .raddr2_i (head_q + PTR_W'(1)),
        .rdata2_o (out2_data_o)
    );

    assign out1_valid_o = (count_q >= CNT_W'(1));
    assign out2_valid_o = (count_q >= CNT_W'(2));
    assign count_o      = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (pop_num_i != 2'd3)
                else $error("instqueue: illegal pop_num_i=3");
            assert (!(push2_valid_i && !push1_valid_i))
                else $error("instqueue: push2 without push1");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040210_instqueue.sv
// Randomised self-checking bench for the instruction queue.
// Reference model: a plain SystemVerilog queue of entries.
module tb_ysyx_22040210_instqueue;
    import ysyx_22040210_instqueue_pkg::*;

    localparam int DEPTH = IQ_DEPTH;
    localparam int EW    = IQ_ENT_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [EW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push1_valid_i;
    ent_t          push1_data_i;
    logic          push2_valid_i;
    ent_t          push2_data_i;
    logic          push_ready_o;
    logic [1:0]    pop_num_i;
    logic          out1_valid_o;
    ent_t          out1_data_o;
    logic          out2_valid_o;
    ent_t          out2_data_o;
    logic [CW-1:0] count_o;

    ysyx_22040210_instqueue #(
        .DEPTH (DEPTH),
        .ENT_W (EW),
        .CNT_W (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .push1_valid_i (push1_valid_i),
        .push1_data_i  (push1_data_i),
        .push2_valid_i (push2_valid_i),
        .push2_data_i  (push2_data_i),
        .push_ready_o  (push_ready_o),
        .pop_num_i     (pop_num_i),
        .out1_valid_o  (out1_valid_o),
        .out1_data_o   (out1_data_o),
        .out2_valid_o  (out2_valid_o),
        .out2_data_o   (out2_data_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    ent_t mq[$];
    ent_t sent[$];
    ent_t popped[$];

    task automatic check(
        input string        tag,
        input logic [255:0] got,
        input logic [255:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t rnd_ent();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom};
        return t[EW-1:0];
    endfunction

    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        check({tag, "_cnt"}, 256'(count_o), 256'(n));
        check({tag, "_v1"}, 256'(out1_valid_o), 256'(n >= 1));
        check({tag, "_v2"}, 256'(out2_valid_o), 256'(n >= 2));
        check({tag, "_rdy"}, 256'(push_ready_o),
              256'(n <= DEPTH - 2));
        if (n >= 1) check({tag, "_d1"}, 256'(out1_data_o), 256'(mq[0]));
        if (n >= 2) check({tag, "_d2"}, 256'(out2_data_o), 256'(mq[1]));
    endtask

    task automatic step(
        input string      tag,
        input logic       v1,
        input ent_t       d1,
        input logic       v2,
        input ent_t       d2,
        input logic [1:0] pop,
        input logic       fl,
        input logic       r
    );
        int  npop;
        bit  rdy;
        rst           = r;
        flush         = fl;
        push1_valid_i = v1;
        push1_data_i  = d1;
        push2_valid_i = v2;
        push2_data_i  = d2;
        pop_num_i     = pop;
        if (r || fl) begin
            mq.delete();
        end else begin
            rdy  = (mq.size() <= DEPTH - 2);
            npop = (int'(pop) < mq.size()) ? int'(pop) : mq.size();
            for (int i = 0; i < npop; i++) begin
                popped.push_back(i == 0 ? out1_data_o : out2_data_o);
                void'(mq.pop_front());
            end
            if (rdy && v1) begin
                mq.push_back(d1);
                sent.push_back(d1);
                if (v2) begin
                    mq.push_back(d2);
                    sent.push_back(d2);
                end
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag, input logic [1:0] pop);
        step(tag, 1'b0, '0, 1'b0, '0, pop, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step("rst", 1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        ent_t a, b;
        logic v1, v2;
        logic [1:0] pop;
        int guard;

        do_reset();
        check("rst_cnt", 256'(count_o), 256'(0));
        check("rst_rdy", 256'(push_ready_o), 256'(1));

        a = rnd_ent();
        b = rnd_ent();
        step("ab", 1'b1, a, 1'b1, b, 2'd0, 1'b0, 1'b0);
        check("ab_out1", 256'(out1_data_o), 256'(a));
        check("ab_out2", 256'(out2_data_o), 256'(b));
        check("ab_cnt", 256'(count_o), 256'(2));

        do_reset();
        for (int i = 0; i < 7; i++)
            step("fill", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
                 2'd0, 1'b0, 1'b0);
        check("fill14_cnt", 256'(count_o), 256'(14));
        check("fill14_rdy", 256'(push_ready_o), 256'(1));
        step("at14", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd2, 1'b0, 1'b0);
        check("at14_cnt", 256'(count_o), 256'(14));
        step("to16", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd0, 1'b0, 1'b0);
        check("full_rdy", 256'(push_ready_o), 256'(0));
        step("drop", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd0, 1'b0, 1'b0);
        check("drop_cnt", 256'(count_o), 256'(16));

        do_reset();
        step("one", 1'b1, rnd_ent(), 1'b0, '0, 2'd0, 1'b0, 1'b0);
        idle("clip", 2'd2);
        check("clip_cnt", 256'(count_o), 256'(0));
        check("clip_v1", 256'(out1_valid_o), 256'(0));
        idle("empty_pop", 2'd2);
        step("e_pushpop", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd2, 1'b0, 1'b0);
        check("e_pushpop_cnt", 256'(count_o), 256'(2));

        do_reset();
        sent.delete();
        popped.delete();
        guard = 0;
        while (sent.size() < 40 && guard < 400) begin
            v1  = 1'($urandom_range(0, 1));
            v2  = v1 & 1'($urandom_range(0, 1));
            pop = 2'($urandom_range(0, 2));
            step("strm", v1, rnd_ent(), v2, rnd_ent(), pop, 1'b0, 1'b0);
            guard++;
        end
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            idle("drain", 2'd2);
            guard++;
        end
        check("strm_sent", 256'(sent.size() >= 40), 256'(1));
        check("strm_len", 256'(popped.size()), 256'(sent.size()));
        for (int i = 0; i < sent.size() && i < popped.size(); i++)
            if (popped[i] !== sent[i])
                check("strm_ord", 256'(popped[i]), 256'(sent[i]));
        check("strm_empty", 256'(count_o), 256'(0));

        do_reset();
        for (int i = 0; i < 4; i++)
            step("f9", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
                 2'd0, 1'b0, 1'b0);
        step("f9", 1'b1, rnd_ent(), 1'b0, '0, 2'd0, 1'b0, 1'b0);
        check("f9_cnt", 256'(count_o), 256'(9));
        step("flush", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd2, 1'b1, 1'b0);
        check("flush_cnt", 256'(count_o), 256'(0));
        check("flush_v2", 256'(out2_valid_o), 256'(0));
        check("flush_rdy", 256'(push_ready_o), 256'(1));

        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
                 2'd1, 1'b0, 1'b0);
        step("mid_rst", 1'b1, rnd_ent(), 1'b1, rnd_ent(),
             2'd1, 1'b1, 1'b1);
        check("mid_rst_cnt", 256'(count_o), 256'(0));

        for (int i = 0; i < 600; i++) begin
            v1  = 1'($urandom_range(0, 3) != 0);
            v2  = v1 & 1'($urandom_range(0, 1));
            pop = 2'($urandom_range(0, 2));
            step("rnd", v1, rnd_ent(), v2, rnd_ent(), pop,
                 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
